// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and the response record shared by the ALU execution unit
package alu_pkg;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  typedef struct packed {
    logic [31:0] Result;
    logic        OverFlow;
    logic        Carry;
    logic        Zero;
    logic        Negative;
    logic        Illegal;
  } alu_resp_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational 32-bit ALU producing result, flags and an illegal-opcode marker
module alu_core
  import alu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  op_i,
  output alu_resp_t   resp_o
);
  logic        is_sub;
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        ovf;
  // sub and slt share one adder computing A + ~B + 1; overflow then reduces to the add rule on b_eff
  always_comb begin
    is_sub = (op_i == ALU_SUB) || (op_i == ALU_SLT);
    b_eff  = is_sub ? ~b_i : b_i;
    sum    = {1'b0, a_i} + {1'b0, b_eff} + 33'(is_sub);
    ovf    = (a_i[31] == b_eff[31]) && (sum[31] != a_i[31]);
    resp_o = '0;
    case (op_i)
      ALU_ADD, ALU_SUB: begin
        resp_o.Result   = sum[31:0];
        resp_o.Carry    = sum[32];
        resp_o.OverFlow = ovf;
      end
      ALU_AND: resp_o.Result = a_i & b_i;
      ALU_OR:  resp_o.Result = a_i | b_i;
      ALU_SLT: resp_o.Result = {31'b0, sum[31] ^ ovf};
      default: resp_o.Illegal = 1'b1;
    endcase
    resp_o.Zero     = (resp_o.Result == 32'b0);
    resp_o.Negative = resp_o.Result[31];
  end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked ALU front end with in-order response FIFO; sticky flags under ALU_EXEC_STICKY_FLAGS_EN
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [31:0]      A,
  input  logic [31:0]      B,
  input  logic [2:0]       ALUControl,
  input  logic [TAG_W-1:0] ReqTag,
  output logic             ResValid,
  input  logic             ResReady,
  output logic [31:0]      Result,
  output logic             OverFlow,
  output logic             Carry,
  output logic             Zero,
  output logic             Negative,
  output logic             Illegal,
  output logic [TAG_W-1:0] ResTag,
  output logic [15:0]      OpCount,
  input  logic             FlagClear,
  output logic [3:0]       StickyFlags
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  alu_resp_t        core_resp, head;
  alu_resp_t        mem_q [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [15:0]      opc_q, opc_d;
  logic             push, pop;
  alu_core u_core (.a_i(A), .b_i(B), .op_i(ALUControl), .resp_o(core_resp));
  assign ReqReady = cnt_q < CW'(DEPTH);
  assign ResValid = cnt_q != '0;
  assign push     = ReqValid && ReqReady;
  assign pop      = ResValid && ResReady;
  // pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wp_d  = push ? wp_q + 1'b1 : wp_q;
    rp_d  = pop ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    opc_d = opc_q + 16'(push);
  end
  // control state, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      opc_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      opc_q <= opc_d;
    end
  end
  // payload storage needs no reset; outputs are masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wp_q] <= core_resp;
      tag_q[wp_q] <= ReqTag;
    end
  end
  assign head     = ResValid ? mem_q[rp_q] : '0;
  assign Result   = head.Result;
  assign OverFlow = head.OverFlow;
  assign Carry    = head.Carry;
  assign Zero     = head.Zero;
  assign Negative = head.Negative;
  assign Illegal  = head.Illegal;
  assign ResTag   = ResValid ? tag_q[rp_q] : '0;
  assign OpCount  = opc_q;
`ifdef ALU_EXEC_STICKY_FLAGS_EN
  logic [3:0] sticky_q, sticky_d;
  // clear takes effect before the new op's flags are merged in
  always_comb begin
    sticky_d = (FlagClear ? 4'b0 : sticky_q) |
               (push ? {core_resp.Negative, core_resp.Zero, core_resp.Carry, core_resp.OverFlow} : 4'b0);
  end
  // sticky flag register
  always_ff @(posedge clk) begin
    if (rst) sticky_q <= '0;
    else sticky_q <= sticky_d;
  end
  assign StickyFlags = sticky_q;
`else
  logic unused_flag_clear;
  assign unused_flag_clear = FlagClear;
  assign StickyFlags       = 4'b0000;
`endif
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: vector table, corner sequences and random scoreboard check of alu_exec_unit
module tb_alu_exec_unit;
  logic        clk = 0, rst = 1;
  logic        ReqValid = 0, ReqReady, ResValid, ResReady = 1;
  logic [31:0] A = 0, B = 0, Result;
  logic [2:0]  ALUControl = 0;
  logic [3:0]  ReqTag = 0, ResTag, StickyFlags;
  logic        OverFlow, Carry, Zero, Negative, Illegal, FlagClear = 0;
  logic [15:0] OpCount;
  int n_vec = 0, n_err = 0;

  alu_exec_unit #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .ReqValid(ReqValid), .ReqReady(ReqReady), .A(A), .B(B),
    .ALUControl(ALUControl), .ReqTag(ReqTag), .ResValid(ResValid), .ResReady(ResReady),
    .Result(Result), .OverFlow(OverFlow), .Carry(Carry), .Zero(Zero), .Negative(Negative),
    .Illegal(Illegal), .ResTag(ResTag), .OpCount(OpCount), .FlagClear(FlagClear),
    .StickyFlags(StickyFlags));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [3:0]  tag;
    logic [31:0] res;
    logic [4:0]  f;
  } vec_t;
  vec_t tv[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {Result, V, C, Z, N, Illegal} from signed/unsigned arithmetic on the operands
  function automatic logic [36:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    longint sa, sb, s;
    logic [31:0] r;
    logic v, c;
    sa = $signed(a);
    sb = $signed(b);
    v = 0;
    c = 0;
    case (op)
      3'd0: begin s = sa + sb; r = a + b; c = ({1'b0, a} + {1'b0, b}) > 33'hFFFFFFFF; v = s != longint'($signed(r)); end
      3'd1: begin s = sa - sb; r = a - b; c = a >= b; v = s != longint'($signed(r)); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      default: return {32'b0, 5'b00101};
    endcase
    return {r, v, c, r == 32'b0, r[31], 1'b0};
  endfunction

  task automatic do_reset;
    @(negedge clk);
    rst = 1;
    ReqValid = 0;
    FlagClear = 0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic [3:0] tag, input logic fc);
    @(negedge clk);
    A = a; B = b; ALUControl = op; ReqTag = tag; FlagClear = fc; ReqValid = 1;
    @(negedge clk);
    ReqValid = 0;
    FlagClear = 0;
  endtask

  logic [40:0] q[$];
  logic [36:0] e;
  logic [15:0] opc;
  logic [3:0]  stk;
  logic        acc, pop;

  initial begin
    tv = '{
      '{32'h10, 32'h20, 3'b000, 4'd3, 32'h30, 5'b00000},
      '{32'h30, 32'h10, 3'b001, 4'd1, 32'h20, 5'b01000},
      '{32'h10, 32'h10, 3'b001, 4'd2, 32'h0, 5'b01100},
      '{32'h7FFFFFFF, 32'h1, 3'b000, 4'd4, 32'h80000000, 5'b10010},
      '{32'hFFFFFFFF, 32'h1, 3'b000, 4'd5, 32'h0, 5'b01100},
      '{32'h5, 32'h10, 3'b101, 4'd6, 32'h1, 5'b00000},
      '{32'hFFFFFFFF, 32'h1, 3'b101, 4'd7, 32'h1, 5'b00000},
      '{32'h1, 32'hFFFFFFFF, 3'b101, 4'd8, 32'h0, 5'b00100},
      '{32'hF0F0, 32'hFF00, 3'b010, 4'd9, 32'hF000, 5'b00000},
      '{32'h80000000, 32'h1, 3'b011, 4'd10, 32'h80000001, 5'b00010},
      '{32'h5, 32'h3, 3'b110, 4'd11, 32'h0, 5'b00101},
      '{32'h80000000, 32'h1, 3'b001, 4'd12, 32'h7FFFFFFF, 5'b11000},
      '{32'hDEAD, 32'hBEEF, 3'b100, 4'd13, 32'h0, 5'b00101},
      '{32'h1, 32'h2, 3'b111, 4'd14, 32'h0, 5'b00101}
    };
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_resvalid", ResValid, 0);
    chk("rst_reqready", ReqReady, 1);
    chk("rst_opcount", OpCount, 0);
    chk("rst_result", {Result, OverFlow, Carry, Zero, Negative, Illegal, ResTag}, 0);
    chk("rst_sticky", StickyFlags, 0);

    for (int i = 0; i < 14; i++) begin
      send(tv[i].a, tv[i].b, tv[i].op, tv[i].tag, 0);
      chk($sformatf("tv%0d_valid", i), ResValid, 1);
      chk($sformatf("tv%0d_result", i), Result, tv[i].res);
      chk($sformatf("tv%0d_flags", i), {OverFlow, Carry, Zero, Negative, Illegal}, tv[i].f);
      chk($sformatf("tv%0d_tag", i), ResTag, tv[i].tag);
      chk($sformatf("tv%0d_opcount", i), OpCount, i + 1);
    end

    do_reset();
    ResReady = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      A = 32'(i * 16 + 1); B = 32'(i); ALUControl = 3'b000; ReqTag = 4'(i); ReqValid = 1;
      chk($sformatf("bp_reqready%0d", i), ReqReady, i < 4);
    end
    @(negedge clk);
    ReqValid = 0;
    chk("bp_opcount", OpCount, 4);
    chk("bp_full", ReqReady, 0);
    ResReady = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_drain_valid%0d", i), ResValid, 1);
      chk($sformatf("bp_drain_tag%0d", i), ResTag, 4'(i));
      chk($sformatf("bp_drain_res%0d", i), Result, 32'(i * 17 + 1));
      if (i == 1) chk("bp_ready_after_pop", ReqReady, 1);
      @(negedge clk);
    end
    chk("bp_empty", ResValid, 0);

    ResReady = 0;
    for (int i = 0; i < 3; i++) send(32'(i), 32'h1, 3'b000, 4'(i + 5), 0);
    chk("mid_queued", OpCount, 7);
    @(negedge clk);
    rst = 1;
    ReqValid = 1;
    @(negedge clk);
    rst = 0;
    ReqValid = 0;
    chk("mid_rst_resvalid", ResValid, 0);
    chk("mid_rst_opcount", OpCount, 0);
    chk("mid_rst_reqready", ReqReady, 1);
    chk("mid_rst_outputs", {Result, OverFlow, Carry, Zero, Negative, Illegal, ResTag}, 0);
    chk("mid_rst_sticky", StickyFlags, 0);

    ResReady = 1;
    send(32'hFFFFFFFF, 32'h1, 3'b000, 4'd1, 0);
    send(32'h10, 32'h20, 3'b000, 4'd2, 0);
`ifdef ALU_EXEC_STICKY_FLAGS_EN
    chk("sticky_or", StickyFlags, 4'b0110);
`else
    chk("sticky_off", StickyFlags, 4'b0000);
`endif
    send(32'h7FFFFFFF, 32'h1, 3'b000, 4'd3, 1);
`ifdef ALU_EXEC_STICKY_FLAGS_EN
    chk("sticky_clear_acc", StickyFlags, 4'b1001);
`else
    chk("sticky_off2", StickyFlags, 4'b0000);
`endif

    do_reset();
    q.delete();
    opc = 0;
    stk = 0;
    for (int k = 0; k < 600; k++) begin
      chk("rnd_reqready", ReqReady, q.size() < 4);
      chk("rnd_resvalid", ResValid, q.size() != 0);
      if (q.size() != 0)
        chk("rnd_head", {Result, OverFlow, Carry, Zero, Negative, Illegal, ResTag}, q[0]);
      chk("rnd_opcount", OpCount, opc);
      chk("rnd_sticky", StickyFlags, stk);
      ReqValid = ($urandom % 4) != 0;
      ResReady = ($urandom % 3) != 0;
      FlagClear = ($urandom % 10) == 0;
      ALUControl = 3'($urandom % 8);
      ReqTag = 4'($urandom);
      case ($urandom % 6)
        0: A = 32'h7FFFFFFF;
        1: A = 32'h80000000;
        2: A = 32'hFFFFFFFF;
        default: A = $urandom;
      endcase
      case ($urandom % 6)
        0: B = 32'h1;
        1: B = A;
        2: B = 32'h80000000;
        default: B = $urandom;
      endcase
      acc = ReqValid && q.size() < 4;
      pop = ResReady && q.size() != 0;
      if (pop) void'(q.pop_front());
      if (acc) begin
        e = ref_alu(A, B, ALUControl);
        q.push_back({e, ReqTag});
        opc++;
      end
`ifdef ALU_EXEC_STICKY_FLAGS_EN
      if (FlagClear) stk = 0;
      if (acc) stk |= {e[1], e[2], e[3], e[4]};
`endif
      @(negedge clk);
    end
    ReqValid = 0;
    FlagClear = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
